// File: rtl/mult_rr_scheduler_if.sv
// Requester, response and multiplier-side signals of the round-robin multiplier scheduler.
// The slave modport is the scheduler; the master modport is everything around it.
interface mult_rr_scheduler_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned PW = 2 * DATA_WIDTH;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_m;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_q;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [NUM_REQ-1:0]            resp_ready;
    logic [PW-1:0]                 resp_product;
    logic                          resp_err;
    logic                          mult_start;
    logic [DATA_WIDTH-1:0]         mult_m;
    logic [DATA_WIDTH-1:0]         mult_q;
    logic [PW-1:0]                 mult_p;
    logic                          mult_done;
    logic                          mult_busy;

    modport slave (
        input  req_valid, req_m, req_q, resp_ready, mult_p, mult_done, mult_busy,
        output req_ready, resp_valid, resp_product, resp_err, mult_start, mult_m, mult_q
    );

    modport master (
        output req_valid, req_m, req_q, resp_ready, mult_p, mult_done, mult_busy,
        input  req_ready, resp_valid, resp_product, resp_err, mult_start, mult_m, mult_q
    );
endinterface

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one iterative multiplier between NUM_REQ requesters,
// with a watchdog that turns a hung multiplier into an error response.
module mult_rr_scheduler #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_rr_scheduler_if.slave   bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PW    = 2 * DATA_WIDTH;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       grant_q, grant_d;
    logic [DATA_WIDTH-1:0]  mult_m_q, mult_m_d;
    logic [DATA_WIDTH-1:0]  mult_q_q, mult_q_d;
    logic [WD_W-1:0]        watchdog_q, watchdog_d;
    logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
    logic [PW-1:0]          resp_product_q, resp_product_d;
    logic                   resp_err_q, resp_err_d;
    logic                   mult_start_q, mult_start_d;

    logic                   win_found;
    logic [PTR_W-1:0]       win_idx;
    logic [PTR_W-1:0]       cand;
    logic                   accept_c;
    logic [NUM_REQ-1:0]     grant_onehot;

    // Winner: first valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign accept_c      = (state_q == ST_IDLE) && !bus.mult_busy && win_found;
    assign bus.req_ready = accept_c ? (NUM_REQ'(1) << win_idx) : '0;
    assign grant_onehot  = NUM_REQ'(1) << grant_q;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_d        = grant_q;
        mult_m_d       = mult_m_q;
        mult_q_d       = mult_q_q;
        watchdog_d     = watchdog_q;
        resp_valid_d   = resp_valid_q;
        resp_product_d = resp_product_q;
        resp_err_d     = resp_err_q;
        mult_start_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    grant_d      = win_idx;
                    mult_m_d     = bus.req_m[32'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
                    mult_q_d     = bus.req_q[32'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
                    mult_start_d = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                watchdog_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                watchdog_d = watchdog_q + WD_W'(1);
                // A done arriving on the last watchdog cycle still counts as success.
                if (bus.mult_done) begin
                    resp_product_d = bus.mult_p;
                    resp_err_d     = 1'b0;
                    resp_valid_d   = grant_onehot;
                    state_d        = ST_RESP;
                end else if (watchdog_q == WD_W'(TIMEOUT - 1)) begin
                    resp_product_d = '0;
                    resp_err_d     = 1'b1;
                    resp_valid_d   = grant_onehot;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready[grant_q]) begin
                    resp_valid_d = '0;
                    rr_ptr_d     = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            grant_q        <= '0;
            mult_m_q       <= '0;
            mult_q_q       <= '0;
            watchdog_q     <= '0;
            resp_valid_q   <= '0;
            resp_product_q <= '0;
            resp_err_q     <= 1'b0;
            mult_start_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_q        <= grant_d;
            mult_m_q       <= mult_m_d;
            mult_q_q       <= mult_q_d;
            watchdog_q     <= watchdog_d;
            resp_valid_q   <= resp_valid_d;
            resp_product_q <= resp_product_d;
            resp_err_q     <= resp_err_d;
            mult_start_q   <= mult_start_d;
        end
    end

    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_product = resp_product_q;
    assign bus.resp_err     = resp_err_q;
    assign bus.mult_start   = mult_start_q;
    assign bus.mult_m       = mult_m_q;
    assign bus.mult_q       = mult_q_q;
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: stub multiplier, transaction-timing reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mult_rr_scheduler;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int PW = 16;
    localparam int TO = 32;
    localparam int NW = N * DW;

    logic clk;
    logic rst_n;

    mult_rr_scheduler_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    mult_rr_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Stub multiplier: product L-1 cycles after its first busy cycle, optional hang.
    int              lat_cfg  = 11;
    bit              hang_cfg = 1'b0;
    bit              stray    = 1'b0;
    logic [7:0]      s_cnt;
    logic [DW-1:0]   s_m, s_q;
    bit              s_hang;
    logic [PW-1:0]   s_junk;
    logic [PW-1:0]   s_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_cnt  <= '0;
            s_m    <= '0;
            s_q    <= '0;
            s_hang <= 1'b0;
        end else if (bus.mult_start) begin
            s_cnt  <= 8'(lat_cfg);
            s_m    <= bus.mult_m;
            s_q    <= bus.mult_q;
            s_hang <= hang_cfg;
        end else if (s_cnt != 0) begin
            s_cnt <= s_cnt - 8'd1;
        end
    end

    assign s_prod        = PW'(s_m) * PW'(s_q);
    assign bus.mult_done = (s_cnt == 8'd1 && !s_hang) || stray;
    assign bus.mult_busy = (s_cnt != 8'd0);
    assign bus.mult_p    = (s_cnt == 8'd1) ? s_prod : s_junk;

    // Reference model: one transaction at a time, timed from its accept cycle.
    int            cyc = 0;
    bit            m_in_flight, m_pending;
    int            m_rr, m_grant, m_acc;
    logic [DW-1:0] m_mm, m_mq;
    int            m_prod;
    bit            m_err;

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (ptr + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic int low_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    typedef struct {
        int idx;
        int prod;
        bit err;
        int lat;
    } resp_t;

    resp_t         resp_log[$];
    logic [N-1:0]  acc_seen;
    logic [N-1:0]  prev_rv;
    logic [N-1:0]  exp_rdy, exp_rv;
    int            pick;
    int            n_ready, n_starts, rv0_cnt, d_acc, d_lat;

    always @(negedge clk) begin
        cyc++;
        acc_seen = bus.req_ready & bus.req_valid;
        if (!rst_n) begin
            chk("rst_req_ready",    64'(bus.req_ready),    64'(0));
            chk("rst_resp_valid",   64'(bus.resp_valid),   64'(0));
            chk("rst_resp_product", 64'(bus.resp_product), 64'(0));
            chk("rst_resp_err",     64'(bus.resp_err),     64'(0));
            chk("rst_mult_start",   64'(bus.mult_start),   64'(0));
            chk("rst_mult_m",       64'(bus.mult_m),       64'(0));
            chk("rst_mult_q",       64'(bus.mult_q),       64'(0));
            m_in_flight = 1'b0;
            m_pending   = 1'b0;
            m_rr        = 0;
            m_mm        = '0;
            m_mq        = '0;
            prev_rv     = '0;
        end else begin
            pick    = rr_pick(bus.req_valid, m_rr);
            exp_rdy = (!m_in_flight && !bus.mult_busy && pick >= 0) ? N'(1) << pick : '0;
            exp_rv  = m_pending ? N'(1) << m_grant : '0;
            chk("req_ready",  64'(bus.req_ready),  64'(exp_rdy));
            chk("mult_start", 64'(bus.mult_start), 64'(m_in_flight && cyc == m_acc + 1));
            chk("mult_m",     64'(bus.mult_m),     64'(m_mm));
            chk("mult_q",     64'(bus.mult_q),     64'(m_mq));
            chk("resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
            if (m_pending) begin
                chk("resp_product", 64'(bus.resp_product), 64'(m_prod));
                chk("resp_err",     64'(bus.resp_err),     64'(m_err));
            end

            if (bus.req_ready != 0) begin n_ready++; d_acc = cyc; end
            if (bus.mult_start) n_starts++;
            if (bus.resp_valid != 0 && prev_rv == 0) d_lat = cyc - d_acc;
            if (bus.resp_valid[0]) rv0_cnt++;
            if ((bus.resp_valid & bus.resp_ready) != 0)
                resp_log.push_back('{low_idx(bus.resp_valid), int'(bus.resp_product), bus.resp_err, d_lat});
            prev_rv = bus.resp_valid;

            if (!m_in_flight) begin
                if (exp_rdy != 0) begin
                    m_in_flight = 1'b1;
                    m_grant     = pick;
                    m_acc       = cyc;
                    m_mm        = bus.req_m[pick*DW +: DW];
                    m_mq        = bus.req_q[pick*DW +: DW];
                end
            end else if (!m_pending) begin
                if (cyc >= m_acc + 2) begin
                    if (bus.mult_done) begin
                        m_pending = 1'b1;
                        m_prod    = int'(m_mm) * int'(m_mq);
                        m_err     = 1'b0;
                    end else if (cyc - m_acc - 2 == TO - 1) begin
                        m_pending = 1'b1;
                        m_prod    = 0;
                        m_err     = 1'b1;
                    end
                end
            end else if (bus.resp_ready[m_grant]) begin
                m_in_flight = 1'b0;
                m_pending   = 1'b0;
                m_rr        = (m_grant + 1) % N;
            end
        end
    end

    // Requester driver: directed requests stay valid until accepted.
    int       dir_pend[N];
    logic [DW-1:0] dir_m[N];
    logic [DW-1:0] dir_q[N];
    bit       rand_mode = 1'b0;
    int       rr_mode   = 0;

    task automatic drive_inputs();
        for (int i = 0; i < N; i++)
            if (acc_seen[i] && dir_pend[i] > 0) dir_pend[i]--;
        s_junk = PW'($urandom);
        if (rand_mode) begin
            bus.req_valid = N'($urandom);
            bus.req_m     = NW'($urandom);
            bus.req_q     = NW'($urandom);
            for (int i = 0; i < N; i++) bus.resp_ready[i] = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       lat_cfg = TO;
                1:       lat_cfg = TO + 1;
                default: lat_cfg = int'($urandom_range(1, 12));
            endcase
            hang_cfg = ($urandom_range(0, 9) == 0);
            stray    = !m_in_flight && ($urandom_range(0, 4) == 0);
        end else begin
            for (int i = 0; i < N; i++) begin
                bus.req_valid[i]         = (dir_pend[i] > 0);
                bus.req_m[i*DW +: DW]    = dir_m[i];
                bus.req_q[i*DW +: DW]    = dir_q[i];
            end
            bus.resp_ready = '1;
            if (rr_mode == 2) bus.resp_ready[0] = (rv0_cnt >= 5);
            stray = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        rand_mode = 1'b0;
        rr_mode   = 0;
        hang_cfg  = 1'b0;
        lat_cfg   = 11;
        for (int i = 0; i < N; i++) dir_pend[i] = 0;
        repeat (3) step();
        rst_n    = 1'b1;
        n_ready  = 0;
        n_starts = 0;
        rv0_cnt  = 0;
        resp_log.delete();
    endtask

    task automatic run_until(input int n, input int budget, input string nm);
        int b;
        b = budget;
        while (resp_log.size() < n && b > 0) begin
            step();
            b--;
        end
        if (resp_log.size() < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: only %0d responses after %0d cycles, required %0d", nm, resp_log.size(), budget, n);
        end
    endtask

    task automatic chk_log(input int k, input string nm, input int idx, input int prod, input bit err);
        if (k < resp_log.size()) begin
            chk({nm, "_idx"},  64'(resp_log[k].idx),  64'(idx));
            chk({nm, "_prod"}, 64'(resp_log[k].prod), 64'(prod));
            chk({nm, "_err"},  64'(resp_log[k].err),  64'(err));
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: response %0d missing, required idx %0d", nm, k, idx);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_m      = '0;
        bus.req_q      = '0;
        bus.resp_ready = '0;
        s_junk         = '0;
        for (int i = 0; i < N; i++) begin
            dir_pend[i] = 0;
            dir_m[i]    = '0;
            dir_q[i]    = '0;
        end

        // Single requester, 13-cycle accept-to-response with an 11-cycle stub.
        do_reset();
        dir_m[0] = 8'd200; dir_q[0] = 8'd150; dir_pend[0] = 1;
        run_until(1, 100, "t1");
        chk_log(0, "t1", 0, 30000, 1'b0);
        if (resp_log.size() > 0) chk("t1_latency", 64'(resp_log[0].lat), 64'(13));
        chk("t1_ready_pulses", 64'(n_ready),  64'(1));
        chk("t1_starts",       64'(n_starts), 64'(1));

        // All four at once: served in index order.
        do_reset();
        lat_cfg = 3;
        for (int i = 0; i < N; i++) begin
            dir_m[i] = 8'((i + 1) * 10); dir_q[i] = 8'd3; dir_pend[i] = 1;
        end
        run_until(4, 200, "t2");
        for (int i = 0; i < N; i++) chk_log(i, "t2", i, (i + 1) * 30, 1'b0);
        chk("t2_starts", 64'(n_starts), 64'(4));

        // Two persistent requesters alternate.
        do_reset();
        lat_cfg = 2;
        dir_m[1] = 8'd7; dir_q[1] = 8'd9;  dir_pend[1] = 3;
        dir_m[2] = 8'd5; dir_q[2] = 8'd11; dir_pend[2] = 3;
        run_until(6, 200, "t3");
        for (int k = 0; k < 6; k++) chk_log(k, "t3", (k % 2 == 0) ? 1 : 2, (k % 2 == 0) ? 63 : 55, 1'b0);

        // Response backpressure: held for five cycles, competing request waits.
        do_reset();
        rr_mode  = 2;
        dir_m[0] = 8'd255; dir_q[0] = 8'd255; dir_pend[0] = 1;
        dir_m[1] = 8'd2;   dir_q[1] = 8'd3;
        step();
        dir_pend[1] = 1;
        run_until(2, 200, "t4");
        chk_log(0, "t4", 0, 65025, 1'b0);
        chk_log(1, "t4b", 1, 6, 1'b0);
        chk("t4_valid_cycles", 64'(rv0_cnt), 64'(6));

        // Hung multiplier produces an error response; the next request is normal.
        do_reset();
        hang_cfg = 1'b1; lat_cfg = 8;
        dir_m[2] = 8'd99; dir_q[2] = 8'd99; dir_pend[2] = 1;
        run_until(1, 200, "t5");
        chk_log(0, "t5", 2, 0, 1'b1);
        if (resp_log.size() > 0) chk("t5_latency", 64'(resp_log[0].lat), 64'(TO + 2));
        hang_cfg = 1'b0;
        dir_m[1] = 8'd12; dir_q[1] = 8'd12; dir_pend[1] = 1;
        run_until(2, 200, "t5b");
        chk_log(1, "t5b", 1, 144, 1'b0);

        // Asynchronous reset in WAIT, then requester 3 is served first.
        do_reset();
        dir_m[0] = 8'd200; dir_q[0] = 8'd201; dir_pend[0] = 1;
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_mult_m",     64'(bus.mult_m),     64'(0));
        chk("t6_async_mult_q",     64'(bus.mult_q),     64'(0));
        chk("t6_async_resp_valid", 64'(bus.resp_valid), 64'(0));
        chk("t6_async_req_ready",  64'(bus.req_ready),  64'(0));
        dir_pend[0] = 0;
        repeat (2) step();
        rst_n = 1'b1;
        resp_log.delete();
        dir_m[3] = 8'd13; dir_q[3] = 8'd17; dir_pend[3] = 1;
        run_until(1, 100, "t6");
        chk_log(0, "t6", 3, 221, 1'b0);

        // Random traffic against the per-cycle model.
        do_reset();
        rand_mode = 1'b1;
        repeat (4000) step();
        rand_mode = 1'b0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
- Round-robin scheduler that shares one iterative 8x8 unsigned multiplier between NUM_REQ requesters.
- Accepts operand pairs over a per-requester valid/ready handshake and launches the multiplier with a one-cycle start pulse.
- Waits for the multiplier's done, then returns the product to the originating requester over a valid/ready response handshake.
- Includes a watchdog so that a hung multiplier cannot deadlock the requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, operand width; the product is 2*DATA_WIDTH.
- TIMEOUT, 32, maximum number of cycles in WAIT before the scheduler aborts with an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_m  in  NUM_REQ*DATA_WIDTH  multiplicands; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_q  in  NUM_REQ*DATA_WIDTH  multipliers; same slicing as req_m.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- resp_valid  out  NUM_REQ  one-hot response valid.
- resp_ready  in  NUM_REQ  per-requester response ready.
- resp_product  out  2*DATA_WIDTH  product of the current response.
- resp_err  out  1  response produced by a timeout; qualified by resp_valid.
- mult_start  out  1  one-cycle start pulse to the multiplier.
- mult_m  out  DATA_WIDTH  multiplicand to the multiplier.
- mult_q  out  DATA_WIDTH  multiplier operand to the multiplier.
- mult_p  in  2*DATA_WIDTH  product from the multiplier; valid when mult_done is high.
- mult_done  in  1  one-cycle completion pulse from the multiplier.
- mult_busy  in  1  multiplier busy flag.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, rr_ptr=0, grant=0;
  - req_ready=0, resp_valid=0, resp_product=0, resp_err=0;
  - mult_start=0, mult_m=0, mult_q=0, watchdog=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Combinationally select the winner: the first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready is the one-hot of the winner, and is nonzero only in IDLE with mult_busy=0.
  - On accept, register grant, mult_m and mult_q from the winner's slice, then go to ISSUE.
  - No valid request, or mult_busy=1: stay in IDLE with req_ready=0.
- ISSUE:
  - mult_start=1 for exactly this cycle; mult_m and mult_q are stable from ISSUE through WAIT.
  - Clear watchdog, go to WAIT.
- WAIT:
  - watchdog increments every cycle.
  - On mult_done=1: resp_product<=mult_p, resp_err<=0, resp_valid<=onehot(grant), go to RESP.
  - If watchdog reaches TIMEOUT-1 without mult_done: resp_product<=0, resp_err<=1, resp_valid<=onehot(grant), go to RESP.
  - If mult_done and the timeout coincide, mult_done wins (resp_err=0).
- RESP:
  - resp_valid, resp_product and resp_err are held stable until resp_ready[grant]=1.
  - On that handshake cycle: resp_valid<=0, rr_ptr<=(grant+1) mod NUM_REQ, go to IDLE.
  - resp_ready bits of other requesters are ignored.
- Latency: accept to mult_start is 1 cycle; mult_done to resp_valid is 1 cycle; there is one transaction in flight at a time.
- An 8-bit multiplier with done two cycles after its 9 iterations gives 13 cycles from accept to resp_valid.
- Fairness: a requester that has just been served has the lowest priority on the next arbitration. Requests deasserted before acceptance are dropped without side effect.
- A stray mult_done outside WAIT is ignored.
- Reset mid-operation returns to the reset values immediately. The multiplier is reset from the same source, so no stale mult_done is expected.
- Products are unsigned, 0..(2^DATA_WIDTH-1)^2, with no truncation.

Test Plan:
- Requester 0 only, m=200, q=150 -> req_ready[0] pulses once, mult_start one cycle later, resp_valid[0] with resp_product=30000, resp_err=0.
- All four valid simultaneously, operands (i+1)*10 x 3, resp_ready tied high -> served in order 0,1,2,3 with products 30,60,90,120; exactly one mult_start per grant.
- Requesters 1 and 2 held valid continuously, rr_ptr=0 -> grants alternate 1,2,1,2 and neither is served twice in a row.
- m=255, q=255, resp_ready[0] held low 5 cycles -> resp_valid[0] and resp_product=65025 stable 5 cycles; IDLE is entered only after resp_ready rises; no new req_ready meanwhile.
- Stub multiplier never asserts mult_done -> after TIMEOUT cycles in WAIT: resp_valid[grant]=1, resp_err=1, resp_product=0; the next request proceeds normally.
- rst_n pulsed low during WAIT -> all outputs return to reset values asynchronously; after release, a request from requester 3 is served first with the correct product.
